mem_latency_ctrl: RTL and testbench

Word-granular backing-memory slave that sits directly downstream of the cache management unit's memory port. It accepts one word read or write per request on the `cs/we/addr` interface and completes it after a fixed, parameterised latency. Completion is a single-cycle `ack` with registered read data. It models main memory for cache write-back and line-fill traffic, and is the memory-side peer the cache controller handshakes with.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_latency_ctrl_word_ram.sv | 32 +++
 rtl/mem_latency_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_latency_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the backing-memory latency model.
//   mem_state_t : controller FSM states (values are visible on mem_state)
//   LAT_WIDTH   : width of the latency counter (latencies 1..255)
//   WORD_W      : data word width
package mem_ctrl_pkg;

   localparam int unsigned LAT_WIDTH = 8;
   localparam int unsigned WORD_W    = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_latency_ctrl_word_ram.sv
// word_ram
//   DEPTH_WORDS x 32 storage array: synchronous write, combinational read
//   through a single shared index. No reset; contents survive rst.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   idx   : word index for both read and write
//   wdata : write data
//   rdata : combinational read of mem[idx]
module word_ram
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_latency_ctrl.sv
// mem_latency_ctrl
//   Word-granular memory slave with fixed, parameterised read/write latency.
//   One request is latched at accept; completion is a one-cycle ack with
//   registered read data.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-low reset
//   mem_cs_i   : request valid
//   mem_we_i   : 1 = write, 0 = read
//   mem_addr_i : byte address (word-aligned; high bits alias)
//   mem_data_i : write data
//   mem_data_o : read data, valid while mem_ack_o = 1, held otherwise
//   mem_ack_o  : one-cycle completion pulse
//   mem_state  : debug copy of the FSM state
module mem_latency_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS   = 1024,
   parameter int unsigned READ_LATENCY  = 4,
   parameter int unsigned WRITE_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_cs_i,
   input  logic              mem_we_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [WORD_W-1:0] mem_data_i,
   output logic [WORD_W-1:0] mem_data_o,
   output logic              mem_ack_o,
   output logic [1:0]        mem_state
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [LAT_WIDTH-1:0] RD_LAT = LAT_WIDTH'(READ_LATENCY);
   localparam logic [LAT_WIDTH-1:0] WR_LAT = LAT_WIDTH'(WRITE_LATENCY);
   localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(1);

   mem_state_t           state;
   logic [LAT_WIDTH-1:0] cnt;

   // Latched request
   logic                 req_we;
   logic [IDX_W-1:0]     req_idx;
   logic [WORD_W-1:0]    req_data;

   logic [IDX_W-1:0]     in_idx;
   logic                 unused_addr;
   logic                 accept;
   logic [LAT_WIDTH-1:0] lat_sel;
   logic                 fast;
   logic                 commit;
   logic                 cur_we;
   logic [IDX_W-1:0]     cur_idx;
   logic [WORD_W-1:0]    cur_data;
   logic                 ram_we;
   logic [WORD_W-1:0]    ram_rdata;

   assign in_idx      = mem_addr_i[IDX_W+1:2];
   assign unused_addr = ^{mem_addr_i[31:IDX_W+2], mem_addr_i[1:0]};

   // A LAT=1 request completes on its own accept edge, so the RAM must see
   // the incoming request directly rather than the (not yet loaded) latches.
   always_comb begin
      accept   = mem_cs_i && ((state == S_IDLE) || (state == S_ACK));
      lat_sel  = mem_we_i ? WR_LAT : RD_LAT;
      fast     = accept && (lat_sel == LAT_ONE);
      commit   = fast || ((state == S_WAIT) && (cnt == LAT_ONE));
      cur_we   = fast ? mem_we_i   : req_we;
      cur_idx  = fast ? in_idx     : req_idx;
      cur_data = fast ? mem_data_i : req_data;
      ram_we   = commit && cur_we;
   end

   word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (cur_idx),
      .wdata (cur_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_we     <= 1'b0;
         req_idx    <= '0;
         req_data   <= '0;
         mem_ack_o  <= 1'b0;
         mem_data_o <= '0;
      end else begin
         case (state)
            S_IDLE, S_ACK: begin
               if (accept) begin
                  req_we   <= mem_we_i;
                  req_idx  <= in_idx;
                  req_data <= mem_data_i;
                  if (lat_sel == LAT_ONE) begin
                     state <= S_ACK;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= lat_sel - LAT_ONE;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               cnt <= cnt - LAT_ONE;
               if (cnt == LAT_ONE) begin
                  state <= S_ACK;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Ack and read data are loaded on the edge that enters S_ACK.
         mem_ack_o <= commit;
         if (commit && !cur_we) begin
            mem_data_o <= ram_rdata;
         end
      end
   end

   assign mem_state = state;

endmodule

// File: tb/tb_mem_latency_ctrl.sv
module tb_mem_latency_ctrl;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   int          cyc;
   int          n_cmp;
   int          n_bad;

   // Default instance (1024 words, latency 4/4)
   logic        cs, we;
   logic [31:0] addr, wdata, rdata;
   logic        ack;
   logic [1:0]  st;

   // Latency-1 instance
   logic        cs1, we1;
   logic [31:0] addr1, wdata1, rdata1;
   logic        ack1;
   logic [1:0]  st1;

   // Reference memory for the default instance
   logic [31:0] ref_mem [1024];
   bit          ref_known [1024];

   mem_latency_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_cs_i(cs), .mem_we_i(we), .mem_addr_i(addr), .mem_data_i(wdata),
      .mem_data_o(rdata), .mem_ack_o(ack), .mem_state(st)
   );

   mem_latency_ctrl #(
      .DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .mem_cs_i(cs1), .mem_we_i(we1), .mem_addr_i(addr1), .mem_data_i(wdata1),
      .mem_data_o(rdata1), .mem_ack_o(ack1), .mem_state(st1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a >> 2) % 32'd1024);
   endfunction

   // Single request on the default instance: cs high for exactly the
   // accepting edge, junk on the inputs afterwards. Returns how many
   // negedges after the accept edge the ack was first seen.
   task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output bit seen);
      @(negedge clk);
      cs = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      lat = 0; seen = 1'b0; rd = 'x;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         if (ack === 1'b1) begin
            seen = 1'b1; lat = k; rd = rdata;
            break;
         end
      end
   endtask

   task automatic test_reset_initial();
      n_cmp++;
      if (ack !== 1'b0 || rdata !== 32'h0 || st !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_initial: ack=%b data=%h state=%0d, need 0/00000000/0", ack, rdata, st);
      end
      n_cmp++;
      if (ack1 !== 1'b0 || rdata1 !== 32'h0 || st1 !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_initial_lat1: ack=%b data=%h state=%0d, need 0/00000000/0", ack1, rdata1, st1);
      end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; bit seen;
      xact(1'b1, 32'h40, 32'hDEADBEEF, lat, rd, seen);
      ref_mem[ref_idx(32'h40)] = 32'hDEADBEEF; ref_known[ref_idx(32'h40)] = 1'b1;
      n_cmp++;
      if (!seen || lat != LAT) begin
         n_bad++;
         $display("FAIL wr_latency: seen=%b lat=%0d, need lat %0d", seen, lat, LAT);
      end
      xact(1'b0, 32'h40, 32'h0, lat, rd, seen);
      n_cmp++;
      if (!seen || lat != LAT) begin
         n_bad++;
         $display("FAIL rd_latency: seen=%b lat=%0d, need lat %0d", seen, lat, LAT);
      end
      n_cmp++;
      if (rd !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL rd_data: got %h, need deadbeef", rd);
      end
      // A write must leave the read-data register untouched.
      xact(1'b1, 32'h44, 32'hCAFEF00D, lat, rd, seen);
      ref_mem[ref_idx(32'h44)] = 32'hCAFEF00D; ref_known[ref_idx(32'h44)] = 1'b1;
      n_cmp++;
      if (!seen || rd !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL data_hold_on_write: seen=%b data=%h, need deadbeef", seen, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      int ack_cyc [4];
      int n, e0, lat;
      logic [31:0] rd; bit seen;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      n = 0;
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = 32'h100; wdata = d[0]; e0 = cyc + 1;
      for (int t = 0; t < 60 && n < 4; t++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            ack_cyc[n] = cyc;
            n++;
            if (n < 4) begin
               addr = 32'h100 + 32'(4 * n); wdata = d[n];
            end else begin
               cs = 1'b0;
            end
         end
      end
      cs = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ref_mem[ref_idx(32'h100 + 32'(4 * i))] = d[i];
         ref_known[ref_idx(32'h100 + 32'(4 * i))] = 1'b1;
      end
      n_cmp++;
      if (n != 4) begin
         n_bad++;
         $display("FAIL b2b_ack_count: got %0d acks, need 4", n);
      end else begin
         n_cmp++;
         if (ack_cyc[0] != e0 + LAT - 1) begin
            n_bad++;
            $display("FAIL b2b_first_ack: at cycle %0d, need %0d", ack_cyc[0], e0 + LAT - 1);
         end
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (ack_cyc[i] - ack_cyc[i-1] != LAT) begin
               n_bad++;
               $display("FAIL b2b_spacing[%0d]: got %0d cycles, need %0d", i, ack_cyc[i] - ack_cyc[i-1], LAT);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, 32'h100 + 32'(4 * i), 32'h0, lat, rd, seen);
         n_cmp++;
         if (!seen || rd !== d[i]) begin
            n_bad++;
            $display("FAIL b2b_readback[%0d]: seen=%b got %h, need %h", i, seen, rd, d[i]);
         end
      end
   endtask

   task automatic test_lat1();
      logic [31:0] d [4];
      int ack_cyc [4];
      int n, e0;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      for (int pass = 0; pass < 2; pass++) begin
         n = 0;
         @(negedge clk);
         cs1 = 1'b1; we1 = (pass == 0); addr1 = 32'h200; wdata1 = d[0]; e0 = cyc + 1;
         for (int t = 0; t < 20 && n < 4; t++) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin
               ack_cyc[n] = cyc;
               if (pass == 1) begin
                  n_cmp++;
                  if (rdata1 !== d[n]) begin
                     n_bad++;
                     $display("FAIL lat1_fill_data[%0d]: got %h, need %h", n, rdata1, d[n]);
                  end
               end
               n++;
               if (n < 4) begin
                  addr1 = 32'h200 + 32'(4 * n); wdata1 = d[n];
               end else begin
                  cs1 = 1'b0;
               end
            end
         end
         cs1 = 1'b0;
         n_cmp++;
         if (n != 4) begin
            n_bad++;
            $display("FAIL lat1_ack_count[pass %0d]: got %0d, need 4", pass, n);
         end else begin
            for (int i = 0; i < 4; i++) begin
               n_cmp++;
               if (ack_cyc[i] != e0 + i) begin
                  n_bad++;
                  $display("FAIL lat1_ack_cycle[%0d]: at %0d, need %0d", i, ack_cyc[i], e0 + i);
               end
            end
         end
         @(negedge clk);
         n_cmp++;
         if (ack1 !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_ack_drop: ack=%b, need 0", ack1);
         end
      end
   endtask

   task automatic test_cancel_alias();
      int lat; logic [31:0] rd; bit seen;
      logic [31:0] d;
      d = $urandom;
      // xact drops cs one cycle after the accept edge
      xact(1'b1, 32'h1000, d, lat, rd, seen);
      ref_mem[ref_idx(32'h1000)] = d; ref_known[ref_idx(32'h1000)] = 1'b1;
      n_cmp++;
      if (!seen || lat != LAT) begin
         n_bad++;
         $display("FAIL cancel_ack: seen=%b lat=%0d, need lat %0d", seen, lat, LAT);
      end
      xact(1'b0, 32'h0000, 32'h0, lat, rd, seen);
      n_cmp++;
      if (!seen || rd !== d) begin
         n_bad++;
         $display("FAIL alias_read: seen=%b got %h, need %h", seen, rd, d);
      end
   endtask

   task automatic test_random();
      int lat, ix; logic [31:0] rd; bit seen;
      logic [31:0] a, d;
      bit w;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ix = (n % 5 == 0) ? 1023 : int'($urandom_range(0, 15));
         a = ($urandom << 12) | 32'(ix << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         w = 1'($urandom_range(0, 1));
         if (!ref_known[ref_idx(a)]) w = 1'b1;
         xact(w, a, d, lat, rd, seen);
         n_cmp++;
         if (!seen || lat != LAT) begin
            n_bad++;
            $display("FAIL rand_latency[%0d]: seen=%b lat=%0d, need %0d", n, seen, lat, LAT);
         end
         if (w) begin
            ref_mem[ref_idx(a)] = d; ref_known[ref_idx(a)] = 1'b1;
         end else begin
            n_cmp++;
            if (rd !== ref_mem[ref_idx(a)]) begin
               n_bad++;
               $display("FAIL rand_read[%0d] addr %h: got %h, need %h", n, a, rd, ref_mem[ref_idx(a)]);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int lat; logic [31:0] rd; bit seen;
      xact(1'b0, 32'h40, 32'h0, lat, rd, seen);
      n_cmp++;
      if (!seen || rdata !== ref_mem[ref_idx(32'h40)]) begin
         n_bad++;
         $display("FAIL pre_reset_read: seen=%b data=%h, need %h", seen, rdata, ref_mem[ref_idx(32'h40)]);
      end
      // still inside the ack cycle, away from any clock edge
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 1'b0 || rdata !== 32'h0 || st !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_async: ack=%b data=%h state=%0d, need 0/00000000/0", ack, rdata, st);
      end
      @(negedge clk);
      rst = 1'b1;
      xact(1'b0, 32'h40, 32'h0, lat, rd, seen);
      n_cmp++;
      if (!seen || rd !== ref_mem[ref_idx(32'h40)]) begin
         n_bad++;
         $display("FAIL ram_survives_reset: got %h, need %h", rd, ref_mem[ref_idx(32'h40)]);
      end
   endtask

   task automatic test_reset_wait();
      int lat, acks; logic [31:0] rd; bit seen;
      logic [31:0] old;
      old = $urandom;
      xact(1'b1, 32'h300, old, lat, rd, seen);
      ref_mem[ref_idx(32'h300)] = old; ref_known[ref_idx(32'h300)] = 1'b1;
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'h12345678;
      @(negedge clk);
      cs = 1'b0;
      n_cmp++;
      if (st !== 2'd1) begin
         n_bad++;
         $display("FAIL wait_state: state=%0d, need 1", st);
      end
      #2 rst = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      n_cmp++;
      if (acks != 0) begin
         n_bad++;
         $display("FAIL reset_wait_no_ack: got %0d acks, need 0", acks);
      end
      xact(1'b0, 32'h300, 32'h0, lat, rd, seen);
      n_cmp++;
      if (!seen || rd !== old) begin
         n_bad++;
         $display("FAIL reset_wait_no_commit: got %h, need %h", rd, old);
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      rst = 1'b0;
      cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      cs1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      for (int i = 0; i < 1024; i++) ref_known[i] = 1'b0;
      repeat (3) @(negedge clk);
      test_reset_initial();
      rst = 1'b1;
      test_write_read();
      test_back_to_back();
      test_lat1();
      test_cancel_alias();
      test_random();
      test_reset_midrun();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
